// File: rtl/alu_pkg.sv
// Shared opcode encoding and constants for the 8-bit ALU.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] DIV_BY_ZERO_Q = 8'hFF;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_MOD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_divider.sv
// Combinational 8-bit unsigned restoring divider shared by DIV and MOD.
module alu_divider
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] num;
    logic [DATA_W:0]   partial;

    // Dividend bits are shifted out MSB-first so no variable bit index is needed.
    always_comb begin
        quo     = '0;
        rem     = '0;
        num     = dividend;
        partial = '0;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            partial = {rem, num[DATA_W-1]};
            num     = {num[DATA_W-2:0], 1'b0};
            if (partial >= {1'b0, divisor}) begin
                partial = partial - {1'b0, divisor};
                quo     = {quo[DATA_W-2:0], 1'b1};
            end else begin
                quo     = {quo[DATA_W-2:0], 1'b0};
            end
            rem = partial[DATA_W-1:0];
        end
    end

    assign div_by_zero = (divisor == '0);
    assign quotient    = div_by_zero ? DIV_BY_ZERO_Q : quo;
    assign remainder   = div_by_zero ? dividend : rem;

endmodule

// File: rtl/alu_top_8b.sv
// Registered 8-bit ALU; logic ops (101/110/111) are built only when ALU_LOGIC_OPS_EN is defined.
module alu_top_8b
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        ctrl_i,
    input  logic [DATA_W-1:0] data0_i,
    input  logic [DATA_W-1:0] data1_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              dbz_o
);

    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              div_by_zero;
    logic [DATA_W-1:0] next_result;
    logic              next_dbz;
    alu_op_e           op;

    alu_divider u_divider (
        .dividend    (data0_i),
        .divisor     (data1_i),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    assign op = alu_op_e'(ctrl_i);

    always_comb begin
        next_result = '0;
        next_dbz    = 1'b0;
        case (op)
            OP_ADD: next_result = data0_i + data1_i;
            OP_SUB: next_result = data0_i - data1_i;
            OP_MUL: next_result = data0_i * data1_i;
            OP_DIV: begin
                next_result = quotient;
                next_dbz    = div_by_zero;
            end
            OP_MOD: begin
                next_result = remainder;
                next_dbz    = div_by_zero;
            end
`ifdef ALU_LOGIC_OPS_EN
            OP_AND: next_result = data0_i & data1_i;
            OP_OR:  next_result = data0_i | data1_i;
            OP_XOR: next_result = data0_i ^ data1_i;
`endif
            default: next_result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o <= '0;
            zero_o   <= 1'b1;
            dbz_o    <= 1'b0;
        end else begin
            result_o <= next_result;
            zero_o   <= (next_result == '0);
            dbz_o    <= next_dbz;
        end
    end

endmodule

// File: tb/tb_alu_top_8b.sv
// Directed self-checking bench for alu_top_8b; expectations follow ALU_LOGIC_OPS_EN.
module tb_alu_top_8b;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [2:0] ctrl_i = 3'b000;
    logic [7:0] data0_i = 8'h00;
    logic [7:0] data1_i = 8'h00;
    logic [7:0] result_o;
    logic       zero_o;
    logic       dbz_o;

    int checks = 0;
    int fails  = 0;

    alu_top_8b dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ctrl_i   (ctrl_i),
        .data0_i  (data0_i),
        .data1_i  (data1_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .dbz_o    (dbz_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic apply(input logic rst, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk_i);
        rst_i   = rst;
        ctrl_i  = op;
        data0_i = a;
        data1_i = b;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] r, input logic z, input logic d);
        checks++;
        assert ({result_o, zero_o, dbz_o} === {r, z, d})
        else begin
            fails++;
            $error("FAIL %s: got result=%02h zero=%b dbz=%b, want result=%02h zero=%b dbz=%b",
                   tag, result_o, zero_o, dbz_o, r, z, d);
        end
    endtask

    initial begin
        apply(1'b1, 3'b010, 8'hAB, 8'h37);  check("reset_c1", 8'h00, 1'b1, 1'b0);
        apply(1'b1, 3'b011, 8'h25, 8'h00);  check("reset_c2", 8'h00, 1'b1, 1'b0);
        apply(1'b0, 3'b000, 8'd1, 8'd1);    check("add_after_reset", 8'h02, 1'b0, 1'b0);

        apply(1'b0, 3'b000, 8'd200, 8'd23); check("add_200_23", 8'hDF, 1'b0, 1'b0);
        // Inputs moving between edges must not disturb the registered outputs.
        #2 ctrl_i = 3'b001; data0_i = 8'h00; data1_i = 8'h01;
        #2 check("hold_between_edges", 8'hDF, 1'b0, 1'b0);
        apply(1'b0, 3'b001, 8'd23, 8'd21);  check("sub_23_21", 8'h02, 1'b0, 1'b0);
        apply(1'b0, 3'b010, 8'd10, 8'd12);  check("mul_10_12", 8'h78, 1'b0, 1'b0);
        apply(1'b0, 3'b011, 8'd10, 8'd2);   check("div_10_2", 8'h05, 1'b0, 1'b0);
        apply(1'b0, 3'b100, 8'd9, 8'd3);    check("mod_9_3", 8'h00, 1'b1, 1'b0);

        apply(1'b0, 3'b000, 8'd200, 8'd100); check("add_wrap", 8'h2C, 1'b0, 1'b0);
        apply(1'b0, 3'b001, 8'd5, 8'd10);    check("sub_wrap", 8'hFB, 1'b0, 1'b0);
        apply(1'b0, 3'b010, 8'd20, 8'd20);   check("mul_wrap", 8'h90, 1'b0, 1'b0);
        apply(1'b0, 3'b000, 8'hFF, 8'h01);   check("add_wrap_zero", 8'h00, 1'b1, 1'b0);

        apply(1'b0, 3'b011, 8'd37, 8'd0);   check("div_by_zero", 8'hFF, 1'b0, 1'b1);
        apply(1'b0, 3'b100, 8'd37, 8'd0);   check("mod_by_zero", 8'h25, 1'b0, 1'b1);
        apply(1'b0, 3'b000, 8'd1, 8'd2);    check("add_after_dbz", 8'h03, 1'b0, 1'b0);

        apply(1'b0, 3'b011, 8'd255, 8'd1);  check("div_255_1", 8'hFF, 1'b0, 1'b0);
        apply(1'b0, 3'b011, 8'd200, 8'd7);  check("div_200_7", 8'h1C, 1'b0, 1'b0);
        apply(1'b0, 3'b100, 8'd200, 8'd7);  check("mod_200_7", 8'h04, 1'b0, 1'b0);
        apply(1'b0, 3'b011, 8'd7, 8'd9);    check("div_7_9", 8'h00, 1'b1, 1'b0);
        apply(1'b0, 3'b100, 8'd7, 8'd9);    check("mod_7_9", 8'h07, 1'b0, 1'b0);
        apply(1'b0, 3'b100, 8'd255, 8'd16); check("mod_255_16", 8'h0F, 1'b0, 1'b0);
        apply(1'b0, 3'b011, 8'd128, 8'd128); check("div_128_128", 8'h01, 1'b0, 1'b0);

`ifdef ALU_LOGIC_OPS_EN
        apply(1'b0, 3'b101, 8'hF0, 8'h3C);  check("and", 8'h30, 1'b0, 1'b0);
        apply(1'b0, 3'b110, 8'hF0, 8'h3C);  check("or", 8'hFC, 1'b0, 1'b0);
        apply(1'b0, 3'b111, 8'hF0, 8'h3C);  check("xor", 8'hCC, 1'b0, 1'b0);
`else
        apply(1'b0, 3'b101, 8'hF0, 8'h3C);  check("and_disabled", 8'h00, 1'b1, 1'b0);
        apply(1'b0, 3'b110, 8'hF0, 8'h3C);  check("or_disabled", 8'h00, 1'b1, 1'b0);
        apply(1'b0, 3'b111, 8'hF0, 8'h3C);  check("xor_disabled", 8'h00, 1'b1, 1'b0);
`endif

        apply(1'b0, 3'b011, 8'd37, 8'd0);   check("dbz_before_reset", 8'hFF, 1'b0, 1'b1);
        apply(1'b1, 3'b010, 8'd15, 8'd15);  check("reset_mid_stream", 8'h00, 1'b1, 1'b0);
        apply(1'b0, 3'b010, 8'd15, 8'd15);  check("mul_15_15", 8'hE1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
